output_writeback: RTL and testbench
===================================

OUTPUT_WRITEBACK -- requirements
Module: output_writeback

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 16, result word width.
- OUTPUT_ADDR_WIDTH, 8, output buffer address width.
- FIFO_DEPTH, 4, skid FIFO entries; power of two, at least 2.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle job start pulse.
- clear, in, 1, synchronous abort.
- matrix_size, in, 8, N; the job writes N*N results.
- act_data, in, DATA_WIDTH, activation result word.
- act_valid, in, 1, act_data is valid.
- act_ready, out, 1, block accepts act_data.
- obuf_wr_en, out, 1, output buffer write strobe.
- obuf_wr_addr, out, OUTPUT_ADDR_WIDTH, output buffer write address.
- obuf_wr_data, out, DATA_WIDTH, output buffer write word.
- obuf_wr_ready, in, 1, output buffer accepts the write this cycle.
- busy, out, 1, a job is active.
- done, out, 1, one-cycle job-complete pulse.
- err_oversize, out, 1, sticky; N*N exceeded the address space.

Function
REQ-003 The state machine SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-004 In IDLE, start SHALL latch total = N*N (16-bit) and move to RUN, clearing the accept and write counters and the FIFO.
REQ-005 Zero size: if N=0 at start, the block SHALL go directly to DONE with no writes.
REQ-006 Oversize: if total > 2^OUTPUT_ADDR_WIDTH, the block SHALL clamp total to 2^OUTPUT_ADDR_WIDTH and set err_oversize.
REQ-007 Input handshake: a word SHALL be accepted when act_valid and act_ready are both high in the same cycle.
REQ-008 act_ready SHALL be high only in RUN, with the FIFO not full, and accept count < total.
REQ-009 An accepted word SHALL enter the FIFO tail; accept count SHALL increment by 1.
REQ-010 In RUN and DRAIN, obuf_wr_en SHALL be high whenever the FIFO is non-empty.
REQ-011 obuf_wr_data SHALL equal the FIFO head; obuf_wr_addr SHALL equal the write count (truncated).
REQ-012 A write completes when obuf_wr_en and obuf_wr_ready are both high; the FIFO SHALL pop and the write count SHALL increment.
REQ-013 While obuf_wr_ready is low, obuf_wr_data and obuf_wr_addr SHALL stay stable.
REQ-014 Latency: an accepted word on an empty FIFO SHALL appear on obuf_wr_en the next cycle.
REQ-015 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-016 Full throughput SHALL be one word per cycle when obuf_wr_ready is held high.
REQ-017 RUN SHALL move to DRAIN when accept count reaches total.
REQ-018 DRAIN SHALL move to DONE on the cycle the write count reaches total.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 busy SHALL be high in RUN and DRAIN, low otherwise.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 clear in any state SHALL next cycle force IDLE, flush the FIFO, and zero the counters, busy, done and obuf_wr_en; clear SHALL take priority over start.
REQ-023 err_oversize SHALL be cleared only by clear or reset.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously go to IDLE, with all counters, pointers and occupancy at 0.
REQ-026 On rst_n low, act_ready, obuf_wr_en, busy, done and err_oversize SHALL be 0, and obuf_wr_addr and obuf_wr_data SHALL be 0.
REQ-027 Reset mid-job SHALL discard all pending data with no further writes.

Structure
REQ-028 The state encoding and the default DATA_WIDTH and OUTPUT_ADDR_WIDTH SHALL live in the shared accelerator package.
REQ-029 The FIFO SHALL be a sub-module, wb_fifo, with push/pop/full/empty and a head-data port.

Verification
REQ-030 N=2, act_valid=1, obuf_wr_ready=1, data 0x0011..0x0014 -> writes to addr 0..3 in order; done one cycle after the 4th write; busy for 5 cycles.
REQ-031 N=2, obuf_wr_ready low for 10 cycles -> exactly 4 words accepted then act_ready=0; addr/data held; all 4 written once ready rises.
REQ-032 N=0 start -> done pulse within 2 cycles, no obuf_wr_en.
REQ-033 N=17 with OUTPUT_ADDR_WIDTH=8 -> err_oversize=1; exactly 256 writes, addr 0..255; done.
REQ-034 N=3, clear after 5 accepts -> next cycle IDLE, busy=0, obuf_wr_en=0; a new N=1 job writes addr 0.
REQ-035 N=3, rst_n pulsed low mid-DRAIN -> all outputs 0 immediately; no writes after release.

Source files
------------

// File: rtl/output_writeback_pkg.sv
// Shared accelerator definitions for the result writeback path: FSM encoding,
// default widths and the job-size helpers.
package output_writeback_pkg;

  localparam int unsigned DEF_DATA_WIDTH        = 16;
  localparam int unsigned DEF_OUTPUT_ADDR_WIDTH = 8;
  localparam int unsigned MSIZE_W               = 8;
  localparam int unsigned SQ_W                  = 16;
  // One bit wider than N*N so a clamped total of 2^16 stays representable.
  localparam int unsigned CNT_W                 = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // Number of addressable output words; widths of 16+ can never be exceeded by N*N.
  function automatic logic [CNT_W-1:0] addr_space(input int unsigned aw);
    return (aw >= SQ_W) ? (CNT_W'(1) << SQ_W) : (CNT_W'(1) << aw);
  endfunction

  function automatic logic [SQ_W-1:0] job_square(input logic [MSIZE_W-1:0] n);
    return SQ_W'(n) * SQ_W'(n);
  endfunction

endpackage

// File: rtl/output_writeback_fifo.sv
// Skid FIFO between the activation stream and the output buffer; the head word
// is held in a register so the write data leaves the block straight from a flop.
module wb_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CNT_FW-1:0] count_n;
  logic [WIDTH-1:0]  head_n;

  // Next occupancy and next head word.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    count_n = count + CNT_FW'(do_push) - CNT_FW'(do_pop);
    head_n  = head_data;
    if (flush) begin
      head_n = '0;
    end else if (do_pop && (count > CNT_FW'(1))) begin
      head_n = mem[rd_ptr + PTR_W'(1)];
    end else if (do_push && (empty || do_pop)) begin
      // Word lands on an empty (or emptying) queue and becomes the head directly.
      head_n = push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      head_data <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      head_data <= head_n;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_n;
      full      <= (count_n == CNT_FW'(DEPTH));
      empty     <= (count_n == '0);
      head_data <= head_n;
    end
  end

  // Storage array carries no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/output_writeback.sv
// Streams N*N activation results into the output buffer at consecutive
// addresses through a small skid FIFO, with done/busy and an oversize flag.
module output_writeback
  import output_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int unsigned OUTPUT_ADDR_WIDTH = DEF_OUTPUT_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic [7:0]                   matrix_size,
  input  logic [DATA_WIDTH-1:0]        act_data,
  input  logic                         act_valid,
  output logic                         act_ready,
  output logic                         obuf_wr_en,
  output logic [OUTPUT_ADDR_WIDTH-1:0] obuf_wr_addr,
  output logic [DATA_WIDTH-1:0]        obuf_wr_data,
  input  logic                         obuf_wr_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err_oversize
);

  localparam int unsigned      FCNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] ADDR_SPACE = addr_space(OUTPUT_ADDR_WIDTH);

  wb_state_e         state;
  wb_state_e         state_n;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  total_n;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  acc_n;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  wr_n;
  logic              err_n;
  logic              busy_n;
  logic [SQ_W-1:0]   sq;
  logic              push;
  logic              pop;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [FCNT_W-1:0] fcnt_n;

  wb_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (act_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (obuf_wr_data)
  );

  // Handshakes, next state and next counters; clear overrides everything.
  always_comb begin
    sq      = job_square(matrix_size);
    push    = act_valid && act_ready && !fifo_full && !clear;
    pop     = obuf_wr_en && obuf_wr_ready && !fifo_empty && !clear;
    flush   = clear || ((state == ST_IDLE) && start);
    state_n = state;
    total_n = total;
    err_n   = err_oversize;
    acc_n   = acc_cnt + CNT_W'(push);
    wr_n    = wr_cnt + CNT_W'(pop);

    case (state)
      ST_IDLE: begin
        if (start) begin
          acc_n = '0;
          wr_n  = '0;
          if (CNT_W'(sq) > ADDR_SPACE) begin
            total_n = ADDR_SPACE;
            err_n   = 1'b1;
          end else begin
            total_n = CNT_W'(sq);
          end
          state_n = (sq == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc_n == total) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr_n == total) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (clear) begin
      state_n = ST_IDLE;
      total_n = '0;
      acc_n   = '0;
      wr_n    = '0;
      err_n   = 1'b0;
    end

    fcnt_n = flush ? '0 : (fifo_count + FCNT_W'(push) - FCNT_W'(pop));
    busy_n = (state_n == ST_RUN) || (state_n == ST_DRAIN);
  end

  // Outputs are registered from next-cycle values so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      total        <= '0;
      acc_cnt      <= '0;
      wr_cnt       <= '0;
      err_oversize <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      act_ready    <= 1'b0;
      obuf_wr_en   <= 1'b0;
      obuf_wr_addr <= '0;
    end else begin
      state        <= state_n;
      total        <= total_n;
      acc_cnt      <= acc_n;
      wr_cnt       <= wr_n;
      err_oversize <= err_n;
      busy         <= busy_n;
      done         <= (state_n == ST_DONE);
      act_ready    <= (state_n == ST_RUN) && (fcnt_n != FCNT_W'(FIFO_DEPTH)) &&
                      (acc_n < total_n);
      obuf_wr_en   <= busy_n && (fcnt_n != '0);
      obuf_wr_addr <= OUTPUT_ADDR_WIDTH'(wr_n);
    end
  end

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback: table of directed jobs, clear and
// reset sequences, then randomized jobs scored against a queue-based model.
module tb_output_writeback;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int SPACE = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          clear;
  logic [7:0]    matrix_size;
  logic [DW-1:0] act_data;
  logic          act_valid;
  logic          act_ready;
  logic          obuf_wr_en;
  logic [AW-1:0] obuf_wr_addr;
  logic [DW-1:0] obuf_wr_data;
  logic          obuf_wr_ready;
  logic          busy;
  logic          done;
  logic          err_oversize;

  int checks = 0;
  int errors = 0;

  output_writeback #(
    .DATA_WIDTH        (DW),
    .OUTPUT_ADDR_WIDTH (AW),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .clear         (clear),
    .matrix_size   (matrix_size),
    .act_data      (act_data),
    .act_valid     (act_valid),
    .act_ready     (act_ready),
    .obuf_wr_en    (obuf_wr_en),
    .obuf_wr_addr  (obuf_wr_addr),
    .obuf_wr_data  (obuf_wr_data),
    .obuf_wr_ready (obuf_wr_ready),
    .busy          (busy),
    .done          (done),
    .err_oversize  (err_oversize)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int pv;
    int pr;
    int hold;
    int exp_fill;
    int exp_total;
    int exp_err;
    int exp_busy;
  } job_t;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_act_ready"}, 32'(act_ready), 0);
    check_eq({tag, "_wr_en"}, 32'(obuf_wr_en), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_err"}, 32'(err_oversize), 0);
    check_eq({tag, "_addr"}, 32'(obuf_wr_addr), 0);
  endtask

  // One job: every word offered is d[i]; model says write i goes to addr i with d[i].
  task automatic run_job(input job_t j);
    logic [DW-1:0] d[$];
    int acc, wr, cyc, busy_cnt, last_wr_cyc, done_cyc, budget;
    bit done_seen;
    d = {};
    for (int i = 0; i < j.exp_total + 1; i++) d.push_back(DW'($urandom));
    acc = 0; wr = 0; cyc = 0; busy_cnt = 0;
    last_wr_cyc = -1; done_cyc = -1; done_seen = 0;
    budget = 30 * j.exp_total + 60;

    @(posedge clk); #1;
    start = 1'b1; matrix_size = 8'(j.n); act_valid = 1'b0; obuf_wr_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    act_valid = (int'($urandom_range(99)) < j.pv);
    act_data = d[0];
    obuf_wr_ready = (cyc >= j.hold) && (int'($urandom_range(99)) < j.pr);

    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_seen = 1;
        done_cyc = cyc;
      end
      if (act_ready) check_eq("ready_bound", 32'(acc < j.exp_total), 1);
      if (obuf_wr_en) begin
        check_eq("wr_has_data", 32'(wr < acc), 1);
        check_eq("wr_addr", 32'(obuf_wr_addr), 32'(wr % SPACE));
        if (wr < d.size()) check_eq("wr_data", 32'(obuf_wr_data), 32'(d[wr]));
        if (obuf_wr_ready) begin
          wr++;
          last_wr_cyc = cyc;
        end
      end
      if (act_valid && act_ready) acc++;
      if (j.exp_fill >= 0 && cyc == j.hold - 1) begin
        check_eq("stall_fill", 32'(acc), 32'(j.exp_fill));
        check_eq("stall_ready_low", 32'(act_ready), 0);
      end
      @(posedge clk); #1;
      cyc++;
      act_valid = (int'($urandom_range(99)) < j.pv);
      act_data = (acc < d.size()) ? d[acc] : '0;
      obuf_wr_ready = (cyc >= j.hold) && (int'($urandom_range(99)) < j.pr);
    end

    check_eq("done_seen", 32'(done_seen), 1);
    check_eq("accepted", 32'(acc), 32'(j.exp_total));
    check_eq("written", 32'(wr), 32'(j.exp_total));
    check_eq("err_oversize", 32'(err_oversize), 32'(j.exp_err));
    if (j.exp_busy >= 0) check_eq("busy_cycles", 32'(busy_cnt), 32'(j.exp_busy));
    if (j.exp_total > 0) check_eq("done_after_last_wr", 32'(done_cyc), 32'(last_wr_cyc + 1));
    else check_eq("zero_done_fast", 32'(done_cyc >= 0 && done_cyc < 2), 1);

    act_valid = 1'b0;
    obuf_wr_ready = 1'b1;
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 0);
    check_eq("post_busy", 32'(busy), 0);
    check_eq("post_wr_en", 32'(obuf_wr_en), 0);
    obuf_wr_ready = 1'b0;
  endtask

  initial begin
    job_t tbl[8];
    job_t rj;
    int acc, cyc, n, err_exp;
    bit seen_drain;

    tbl[0] = '{2,   100, 100, 0,  -1, 4,   0, 5};
    tbl[1] = '{2,   100, 100, 10, 4,  4,   0, -1};
    tbl[2] = '{0,   100, 100, 0,  -1, 0,   0, 0};
    tbl[3] = '{5,   60,  50,  0,  -1, 25,  0, -1};
    tbl[4] = '{16,  100, 100, 0,  -1, 256, 0, 257};
    tbl[5] = '{17,  100, 100, 0,  -1, 256, 1, 257};
    tbl[6] = '{1,   100, 100, 0,  -1, 1,   1, 2};
    tbl[7] = '{255, 80,  70,  0,  -1, 256, 1, -1};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; matrix_size = '0;
    act_data = '0; act_valid = 1'b0; obuf_wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_data", 32'(obuf_wr_data), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_job(tbl[i]);

    // Clear after five accepts, with start asserted alongside to test priority.
    @(posedge clk); #1;
    start = 1'b1; matrix_size = 8'd3; act_valid = 1'b0; obuf_wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; act_valid = 1'b1; act_data = '0;
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 40) begin
      @(negedge clk);
      if (act_valid && act_ready) acc++;
      @(posedge clk); #1;
      cyc++;
      act_data = DW'(acc);
    end
    check_eq("clear_accepts", 32'(acc), 5);
    clear = 1'b1; start = 1'b1; matrix_size = 8'd2;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0; act_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("clear");
    err_exp = 0;
    run_job('{1, 100, 100, 0, -1, 1, 0, 2});

    // Randomized jobs; expected totals and flag come from plain arithmetic.
    for (int k = 0; k < 16; k++) begin
      n = ($urandom_range(7) == 0) ? int'($urandom_range(16, 24)) : int'($urandom_range(0, 9));
      err_exp = (err_exp != 0 || n * n > SPACE) ? 1 : 0;
      rj.n = n;
      rj.pv = int'($urandom_range(25, 100));
      rj.pr = int'($urandom_range(25, 100));
      rj.hold = ($urandom_range(3) == 0) ? int'($urandom_range(1, 8)) : 0;
      rj.exp_fill = -1;
      rj.exp_total = (n * n > SPACE) ? SPACE : n * n;
      rj.exp_err = err_exp;
      rj.exp_busy = -1;
      run_job(rj);
    end

    // Reset while draining: outputs drop at once and nothing is written afterwards.
    @(posedge clk); #1;
    start = 1'b1; matrix_size = 8'd3; act_valid = 1'b0; obuf_wr_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; act_valid = 1'b1; act_data = 16'h0abc;
    seen_drain = 0; cyc = 0;
    while (!seen_drain && cyc < 60) begin
      @(negedge clk);
      if (busy && !act_ready && obuf_wr_en && cyc > 7) seen_drain = 1;
      @(posedge clk); #1;
      cyc++;
      obuf_wr_ready = (cyc >= 6) && !seen_drain;
    end
    check_eq("reached_drain", 32'(seen_drain), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    check_eq("mid_reset_data", 32'(obuf_wr_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    obuf_wr_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("post_reset_wr_en", 32'(obuf_wr_en), 0);
      check_eq("post_reset_busy", 32'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
